// File: rtl/sam_wait_memory.sv
// Single-port word memory with a configurable number of wait states per access.
// A request is captured on the accepting edge, optionally held for WAIT_STATES
// cycles, then completed; Ready pulses for one cycle with Err flagging an
// out-of-range address.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no request outstanding, ready to accept
// WAIT   | request held, down-counter running, En ignored
// RESP   | access completed on the entering edge; Ready high, may accept
module sam_wait_memory #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              En,
    input  logic              Rw,
    input  logic [ADDR_W-1:0] Address_Bus,
    input  logic [DATA_W-1:0] Data_In,
    output logic [DATA_W-1:0] Data_Out,
    output logic              Ready,
    output logic              Err,
    output logic              Busy
);

    localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]        WS      = 4'(WAIT_STATES);
    // One extra bit so DEPTH == 2**ADDR_W is representable and no address aliases.
    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                accept, complete;

    logic                h_rw;
    logic [ADDR_W-1:0]   h_addr;
    logic [DATA_W-1:0]   h_data;

    logic                a_rw;
    logic [ADDR_W-1:0]   a_addr;
    logic [DATA_W-1:0]   a_data;
    logic [IDX_W-1:0]    a_idx;
    logic                in_range;
    logic                mem_we;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DATA_W-1:0]   dout_q;
    logic                err_q;

    // With no wait states the access completes on the accepting edge, so the
    // live inputs are used; otherwise the held copy is used.
    always_comb begin
        a_rw     = Rw;
        a_addr   = Address_Bus;
        a_data   = Data_In;
        if (state_q == S_WAIT) begin
            a_rw   = h_rw;
            a_addr = h_addr;
            a_data = h_data;
        end
        a_idx    = a_addr[IDX_W-1:0];
        in_range = ({1'b0, a_addr} < DEPTH_L);
        mem_we   = complete && !a_rw && in_range;
    end

    // Next-state, counter and accept/complete strobes.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        accept   = 1'b0;
        complete = 1'b0;
        case (state_q)
            S_IDLE, S_RESP: begin
                if (En) begin
                    accept = 1'b1;
                    if (WAIT_STATES == 0) begin
                        complete = 1'b1;
                        state_d  = S_RESP;
                    end else begin
                        cnt_d   = WS;
                        state_d = S_WAIT;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    cnt_d    = 4'd0;
                    complete = 1'b1;
                    state_d  = S_RESP;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // State, counter, held request and registered response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            h_rw    <= 1'b0;
            h_addr  <= '0;
            h_data  <= '0;
            dout_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                h_rw   <= Rw;
                h_addr <= Address_Bus;
                h_data <= Data_In;
            end
            err_q <= complete && !in_range;
            if (complete && a_rw) begin
                dout_q <= in_range ? mem[a_idx] : '0;
            end
        end
    end

    // Storage array; reset only blocks writes, contents survive it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
        end else if (mem_we) begin
            mem[a_idx] <= a_data;
        end
    end

    assign Data_Out = dout_q;
    assign Ready    = (state_q == S_RESP);
    assign Busy     = (state_q == S_WAIT);
    assign Err      = err_q;

endmodule

// File: tb/tb_sam_wait_memory.sv
// Bench for sam_wait_memory: three instances (no wait states, three wait
// states, wide 16/10/1024 with two wait states) share one random stimulus
// stream; a queue-based scoreboard checks each against a transaction model.
module tb_sam_wait_memory;

    logic        clk;
    logic        rst;
    logic        en;
    logic        rw;
    logic [9:0]  addr;
    logic [15:0] din;

    logic [7:0]  dout0, dout1;
    logic [15:0] dout2;
    logic [2:0]  rdy, err, bsy;
    logic [15:0] dout_a [3];

    assign dout_a[0] = {8'h00, dout0};
    assign dout_a[1] = {8'h00, dout1};
    assign dout_a[2] = dout2;

    sam_wait_memory #(.WAIT_STATES(0)) u_ws0 (
        .clk(clk), .rst(rst), .En(en), .Rw(rw),
        .Address_Bus(addr[7:0]), .Data_In(din[7:0]),
        .Data_Out(dout0), .Ready(rdy[0]), .Err(err[0]), .Busy(bsy[0]));

    sam_wait_memory #(.WAIT_STATES(3)) u_ws3 (
        .clk(clk), .rst(rst), .En(en), .Rw(rw),
        .Address_Bus(addr[7:0]), .Data_In(din[7:0]),
        .Data_Out(dout1), .Ready(rdy[1]), .Err(err[1]), .Busy(bsy[1]));

    sam_wait_memory #(.DATA_W(16), .ADDR_W(10), .DEPTH(1024), .WAIT_STATES(2)) u_wide (
        .clk(clk), .rst(rst), .En(en), .Rw(rw),
        .Address_Bus(addr), .Data_In(din),
        .Data_Out(dout2), .Ready(rdy[2]), .Err(err[2]), .Busy(bsy[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic        rw;
        logic [9:0]  a;
        logic [15:0] d;
    } req_t;

    typedef struct {
        logic        err;
        logic [15:0] dout;
    } rsp_t;

    req_t        pr [3];
    bit          pv [3];
    rsp_t        rq [3][$];
    logic [15:0] mem_m [3][1024];
    logic [15:0] dout_m [3];
    rsp_t        mon_r;
    int          cyc;
    int          checks;
    int          failures;

    function automatic int ws_k(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 3 : 2);
    endfunction

    function automatic int dep_k(input int k);
        return (k == 2) ? 1024 : 64;
    endfunction

    task automatic check(input string name, input int k, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d actual=%h expected=%h cyc=%0d", name, k, act, exp, cyc);
        end
    endtask

    // Completion of a held transaction: apply it to the model memory and queue the response.
    task automatic model_complete(input int k);
        logic oor;
        oor   = (int'(pr[k].a) >= dep_k(k));
        pv[k] = 1'b0;
        if (pr[k].rw) dout_m[k] = oor ? 16'h0000 : mem_m[k][pr[k].a];
        else if (!oor) mem_m[k][pr[k].a] = pr[k].d;
        rq[k].push_back('{oor, dout_m[k]});
    endtask

    // Transaction model: an accepted request finishes WAIT_STATES edges later.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                if (!pv[k] && en) begin
                    pv[k]     = 1'b1;
                    pr[k].due = cyc + ws_k(k);
                    pr[k].rw  = rw;
                    pr[k].a   = (k == 2) ? addr : {2'b00, addr[7:0]};
                    pr[k].d   = (k == 2) ? din : {8'h00, din[7:0]};
                end
                if (pv[k] && pr[k].due == cyc) model_complete(k);
            end
        end
    end

    // Monitor: pops the scoreboard whenever a response is due and compares.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            check("busy", k, 16'(bsy[k]), 16'(pv[k]));
            check("ready", k, 16'(rdy[k]), 16'(rq[k].size() != 0));
            if (rq[k].size() != 0) begin
                mon_r = rq[k].pop_front();
                check("err", k, 16'(err[k]), 16'(mon_r.err));
                check("data_out", k, dout_a[k], mon_r.dout);
            end else begin
                check("err_idle", k, 16'(err[k]), 16'h0000);
            end
            check("data_hold", k, dout_a[k], dout_m[k]);
        end
    end

    task automatic step(input logic e, input logic r, input logic [9:0] a, input logic [15:0] d);
        en   = e;
        rw   = r;
        addr = a;
        din  = d;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 10'h000, 16'h0000);
    endtask

    task automatic zero_check();
        for (int k = 0; k < 3; k++) begin
            check("rst_data_out", k, dout_a[k], 16'h0000);
            check("rst_ready", k, 16'(rdy[k]), 16'h0000);
            check("rst_err", k, 16'(err[k]), 16'h0000);
            check("rst_busy", k, 16'(bsy[k]), 16'h0000);
        end
    endtask

    // Called just after a falling clock edge; a read of ra is presented so it
    // is accepted on the first rising edge after release.
    task automatic pulse_reset(input logic [9:0] ra);
        en = 1'b0;
        #2 rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            pv[k] = 1'b0;
            rq[k].delete();
            dout_m[k] = 16'h0000;
        end
        #1 zero_check();
        @(negedge clk);
        @(negedge clk);
        en   = 1'b1;
        rw   = 1'b1;
        addr = ra;
        din  = 16'h0000;
        #2 rst = 1'b1;
        @(negedge clk);
    endtask

    function automatic logic [9:0] pick_addr();
        int i;
        i = int'($urandom_range(0, 79));
        return (i < 72) ? 10'(i) : 10'(1016 + i - 72);
    endfunction

    initial begin
        rst = 1'b1; en = 1'b0; rw = 1'b0; addr = '0; din = '0;
        cyc = 0; checks = 0; failures = 0;
        for (int k = 0; k < 3; k++) begin
            pv[k] = 1'b0;
            dout_m[k] = 16'h0000;
        end
        #2 rst = 1'b0;
        #1 zero_check();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Give every instance a known value at each address the test touches.
        for (int i = 0; i < 80; i++) begin
            step(1'b1, 1'b0, (i < 72) ? 10'(i) : 10'(1016 + i - 72), 16'($urandom));
            idle(4);
        end

        // Write then immediate read of the same word.
        step(1'b1, 1'b0, 10'd3, 16'h00A5);
        step(1'b1, 1'b1, 10'd3, 16'h0000);
        idle(5);

        // Back-to-back reads with En held high.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 10'(i), 16'($urandom));
        idle(5);

        // Address 64: out of range for the 64-deep instances, then check word 0.
        step(1'b1, 1'b0, 10'd64, 16'h00FF);
        idle(4);
        step(1'b1, 1'b1, 10'd64, 16'h0000);
        idle(4);
        step(1'b1, 1'b1, 10'd0, 16'h0000);
        idle(4);

        // Top word of the wide instance.
        step(1'b1, 1'b0, 10'd1023, 16'hBEEF);
        idle(4);
        step(1'b1, 1'b1, 10'd1023, 16'h0000);
        idle(4);

        // Reset while the wait-state instances hold a write; the write is lost.
        step(1'b1, 1'b0, 10'd9, 16'h0011);
        pulse_reset(10'd9);
        idle(5);

        // Random traffic with one reset in the middle.
        for (int n = 0; n < 600; n++) begin
            if (n == 300) begin
                pulse_reset(pick_addr());
            end else begin
                step(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), pick_addr(), 16'($urandom));
            end
        end
        idle(8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sam_wait_memory.md
SAM_WAIT_MEMORY -- requirements
Module: sam_wait_memory

Interface
REQ-001 SHALL provide parameter DATA_W, default 8, data word width in bits.
REQ-002 SHALL provide parameter ADDR_W, default 8, address bus width in bits.
REQ-003 SHALL provide parameter DEPTH, default 64, number of implemented words; legal range is 1 to 2^ADDR_W.
REQ-004 SHALL provide parameter WAIT_STATES, default 0, extra cycles inserted before each access completes; legal range is 0 to 15.
REQ-005 SHALL provide port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-006 SHALL provide port rst, input, 1 bit, asynchronous active-low reset.
REQ-007 SHALL provide port En, input, 1 bit, access request.
REQ-008 SHALL provide port Rw, input, 1 bit, 1 = read, 0 = write.
REQ-009 SHALL provide port Address_Bus, input, ADDR_W bits, word address.
REQ-010 SHALL provide port Data_In, input, DATA_W bits, write data.
REQ-011 SHALL provide port Data_Out, output, DATA_W bits, registered read data.
REQ-012 SHALL provide port Ready, output, 1 bit, one-cycle completion pulse.
REQ-013 SHALL provide port Err, output, 1 bit, out-of-range flag, valid while Ready=1.
REQ-014 SHALL provide port Busy, output, 1 bit, high while a request is held and not yet complete.

Function
REQ-015 SHALL implement a three-state FSM: IDLE, WAIT, RESP.
REQ-016 SHALL accept a request on a rising edge where En=1 and the state is IDLE or RESP.
REQ-017 SHALL ignore En while in WAIT; the accepted request is never overwritten.
REQ-018 SHALL capture Rw, Address_Bus and Data_In at the accepting edge; later input changes do not affect the held request.
REQ-019 With WAIT_STATES=0, SHALL perform the access at the accepting edge and go to RESP.
REQ-020 With WAIT_STATES>0, SHALL go to WAIT and load a down-counter with WAIT_STATES.
REQ-021 In WAIT, SHALL decrement the counter each edge and, on the edge where it reaches 0, perform the access and go to RESP.
REQ-022 Ready SHALL be 1 exactly during RESP, giving a latency of 1+WAIT_STATES cycles from the accepting edge.
REQ-023 From RESP, SHALL go to IDLE when En=0, or accept a new request when En=1, so WAIT_STATES=0 sustains one access per cycle.
REQ-024 Busy SHALL be 1 in WAIT and 0 in IDLE and RESP.
REQ-025 Read: on the completion edge, SHALL load Data_Out with mem[addr]; Data_Out then holds until the next read completes.
REQ-026 Write: on the completion edge, SHALL store the held data into mem[addr]; Data_Out is unchanged.
REQ-027 An address >= DEPTH SHALL be out of range.
REQ-028 An out-of-range write SHALL leave memory unchanged.
REQ-029 An out-of-range read SHALL load Data_Out with 0.
REQ-030 Err SHALL be 1 during the RESP of an out-of-range access and 0 at all other times.
REQ-031 A read of an address that was written at the previous completion edge SHALL return the new value, with no bypass hazard.
REQ-032 Full-width addresses SHALL be compared without truncation; there is no aliasing or wrap-around.

Reset
REQ-033 rst=0 SHALL immediately force state IDLE, counter 0, Data_Out=0, Ready=0, Err=0 and Busy=0, independent of clk.
REQ-034 Reset SHALL NOT alter memory contents.
REQ-035 A request in WAIT when rst falls SHALL be discarded with no memory write.
REQ-036 The first request SHALL be accepted on the first rising edge after rst has returned to 1.

Verification
REQ-037 WAIT_STATES=0: write 0xA5 to address 3, then read address 3 on the next cycle -> Ready on the two cycles after acceptance, and Data_Out=0xA5 on the second.
REQ-038 WAIT_STATES=3: read address 5 holding 0x7E -> Busy=1 for 3 cycles, then Ready=1 and Data_Out=0x7E in cycle 4; En pulses during WAIT are ignored.
REQ-039 DEPTH=64: write 0xFF to address 64, then read address 64 -> both accesses give Ready=1 and Err=1, the read gives Data_Out=0x00, and mem[0] is unchanged.
REQ-040 WAIT_STATES=2: accept a write of 0x11 to address 9, assert rst=0 during WAIT -> outputs 0 at once, and a later read of address 9 returns its prior value.
REQ-041 WAIT_STATES=0, En held at 1, read addresses 0 to 7 on consecutive cycles -> Ready stays 1 and Data_Out follows mem[0..7] with one cycle of latency.
REQ-042 DATA_W=16, ADDR_W=10, DEPTH=1024: write 0xBEEF to address 1023 and read it back -> Data_Out=0xBEEF, Err=0.
